// File: rtl/mips_pkg.sv
// Shared widths, constants and fetch FSM encoding for the MIPS front end.
package mips_pkg;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small output buffer for fetched words: DEPTH entries, push/pop/clear,
// occupancy count and head-of-queue output.
module fetch_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage, wrapping pointers and occupancy; clear drops everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues 1-cycle-latency imem reads for pc_in,
// buffers returned words with their PC, hands them to decode over
// valid/ready, back-pressures the PC and flushes on redirect.
module ifetch_unit #(
  parameter int unsigned PC_W    = mips_pkg::PC_W,
  parameter int unsigned INSTR_W = mips_pkg::INSTR_W,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               redirect,
  output logic               pc_stall,
  output logic               imem_en,
  output logic [PC_W-3:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_misalign,
  input  logic               dec_ready
);

  import mips_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = INSTR_W + PC_W + 1;

  fetch_state_t    state;
  fetch_state_t    state_next;

  logic            inflight;
  logic [PC_W-1:0] infl_pc;
  logic            infl_mis;

  logic [AW:0]     count;
  logic [EW-1:0]   head;
  logic [AW+1:0]   occ;

  logic            active;
  logic            flush;
  logic            squash;
  logic            push;
  logic            deq;
  logic            issue;

  assign active      = (state != S_IDLE);
  assign flush       = redirect & active;
  // The response to a fetch issued last cycle lands in the redirect cycle
  // itself, so squashing it is just suppressing that push.
  assign squash      = inflight & redirect;
  assign push        = inflight & ~squash;
  assign instr_valid = (count != '0) & ~redirect;
  assign deq         = instr_valid & dec_ready;
  // Slots that will be committed after this edge: buffered + returning - leaving.
  assign occ         = {1'b0, count} + {{(AW+1){1'b0}}, inflight}
                     - {{(AW+1){1'b0}}, deq};
  assign issue       = active & ~redirect & (occ < (AW+2)'(DEPTH));
  assign imem_addr   = pc_in[PC_W-1:2];

  assign {instr, instr_pc, instr_misalign} = head;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_rdata, infl_pc, infl_mis}),
    .pop       (deq),
    .clear     (flush),
    .count     (count),
    .head      (head)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Tracks the single outstanding read and the PC it was issued for.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      infl_pc  <= '0;
      infl_mis <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        infl_pc  <= pc_in;
        infl_mis <= (pc_in[1:0] != 2'b00);
      end
    end
  end

  // Next-state and issue/stall outputs.
  always_comb begin
    state_next = state;
    imem_en    = 1'b0;
    pc_stall   = 1'b1;
    case (state)
      S_IDLE:  state_next = S_RUN;
      S_RUN:   if (redirect) state_next = S_FLUSH;
      S_FLUSH: if (!redirect) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
    if (issue) begin
      imem_en  = 1'b1;
      pc_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit against a queue-based reference model.
module tb_ifetch_unit;

  import mips_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [9:0]  pc_in;
  logic        redirect;
  logic        pc_stall;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_misalign;
  logic        dec_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state: what decode should see, expressed as a queue of PCs.
  int          phase;      // 0 = not yet running, 1 = running, 2 = flushing
  logic [9:0]  q[$];
  bit          m_infl;
  logic [9:0]  m_infl_pc;
  logic [9:0]  pc;
  logic [9:0]  target;

  bit          exp_valid;
  bit          exp_issue;
  bit          m_deq;
  logic [9:0]  exp_pc;
  logic [31:0] exp_instr;
  bit          exp_mis;

  ifetch_unit #(
    .PC_W    (10),
    .INSTR_W (32),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .redirect       (redirect),
    .pc_stall       (pc_stall),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_misalign (instr_misalign),
    .dec_ready      (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address a holds 0xA0 + a.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'hA0 + {24'd0, imem_addr};
  end

  task automatic model_reset();
    phase  = 0;
    q.delete();
    m_infl = 1'b0;
  endtask

  // Expected outputs for the current cycle from model state and driven inputs.
  task automatic model_eval();
    exp_valid = (q.size() != 0) && !redirect;
    m_deq     = exp_valid && dec_ready;
    exp_issue = (phase != 0) && !redirect &&
                ((q.size() + int'(m_infl) - int'(m_deq)) < DEPTH);
    exp_pc    = (q.size() != 0) ? q[0] : 10'd0;
    exp_instr = 32'hA0 + 32'(exp_pc >> 2);
    exp_mis   = (exp_pc[1:0] != 2'b00);
  endtask

  // Clock edge: update model and the PC register model, then drive the new PC.
  task automatic advance();
    @(posedge clk);
    if (redirect && phase != 0) begin
      q.delete();
      phase = 2;
    end else begin
      if (m_deq) void'(q.pop_front());
      if (m_infl) q.push_back(m_infl_pc);
      phase = 1;
    end
    m_infl    = exp_issue;
    m_infl_pc = pc_in;
    if (redirect) pc = target;
    else if (exp_issue) pc = pc + 10'd4;
    #1;
    pc_in    = pc;
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    redirect  = 1'b0;
    dec_ready = 1'b1;
    pc        = 10'd100;
    pc_in     = 10'd100;
    target    = 10'd0;
    model_reset();
    #1;
    checks++;
    if ({pc_stall, imem_en, instr_valid, instr, instr_pc, instr_misalign} !==
        {1'b1, 1'b0, 1'b0, 32'd0, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs stall/en/valid/instr/pc/mis act %b/%b/%b/%h/%0d/%b exp 1/0/0/0/0/0",
               pc_stall, imem_en, instr_valid, instr, instr_pc, instr_misalign);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); model_eval();
      checks++;
      if ({pc_stall, imem_en, instr_valid, imem_addr} !== {~exp_issue, exp_issue, exp_valid, pc_in[9:2]}) begin
        errors++;
        $display("FAIL start_handshake c=%0d stall/en/valid/addr act %b/%b/%b/%0d exp %b/%b/%b/%0d",
                 c, pc_stall, imem_en, instr_valid, imem_addr, ~exp_issue, exp_issue, exp_valid, pc_in[9:2]);
      end
      if (exp_valid) begin
        checks++;
        if ({instr, instr_pc, instr_misalign} !== {exp_instr, exp_pc, exp_mis}) begin
          errors++;
          $display("FAIL start_head c=%0d instr/pc/mis act %h/%0d/%b exp %h/%0d/%b",
                   c, instr, instr_pc, instr_misalign, exp_instr, exp_pc, exp_mis);
        end
      end
      if (c == 1) begin
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 8'd25) begin
          errors++;
          $display("FAIL first_fetch en/addr act %b/%0d exp 1/25", imem_en, imem_addr);
        end
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 10'(100 + 4 * (c - 3)) || pc_stall !== 1'b0) begin
          errors++;
          $display("FAIL first_stream c=%0d valid/pc/stall act %b/%0d/%b exp 1/%0d/0",
                   c, instr_valid, instr_pc, pc_stall, 100 + 4 * (c - 3));
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 10; c++) begin
      dec_ready = (c >= 5);
      @(negedge clk); model_eval();
      checks++;
      if ({pc_stall, imem_en, instr_valid, imem_addr} !== {~exp_issue, exp_issue, exp_valid, pc_in[9:2]}) begin
        errors++;
        $display("FAIL bp_handshake c=%0d stall/en/valid/addr act %b/%b/%b/%0d exp %b/%b/%b/%0d",
                 c, pc_stall, imem_en, instr_valid, imem_addr, ~exp_issue, exp_issue, exp_valid, pc_in[9:2]);
      end
      if (exp_valid) begin
        checks++;
        if ({instr, instr_pc, instr_misalign} !== {exp_instr, exp_pc, exp_mis}) begin
          errors++;
          $display("FAIL bp_head c=%0d instr/pc/mis act %h/%0d/%b exp %h/%0d/%b",
                   c, instr, instr_pc, instr_misalign, exp_instr, exp_pc, exp_mis);
        end
      end
      if (c >= 1 && c < 5) begin
        checks++;
        if (pc_stall !== 1'b1) begin
          errors++;
          $display("FAIL bp_full_stall c=%0d act %b exp 1", c, pc_stall);
        end
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    dec_ready = 1'b1;
    redirect  = 1'b1;
    target    = 10'd180;
    @(negedge clk); model_eval();
    checks++;
    if ({instr_valid, imem_en, pc_stall} !== 3'b001) begin
      errors++;
      $display("FAIL redirect_cycle valid/en/stall act %b/%b/%b exp 0/0/1", instr_valid, imem_en, pc_stall);
    end
    advance();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); model_eval();
      checks++;
      if ({pc_stall, imem_en, instr_valid, imem_addr} !== {~exp_issue, exp_issue, exp_valid, pc_in[9:2]}) begin
        errors++;
        $display("FAIL redir_handshake c=%0d stall/en/valid/addr act %b/%b/%b/%0d exp %b/%b/%b/%0d",
                 c, pc_stall, imem_en, instr_valid, imem_addr, ~exp_issue, exp_issue, exp_valid, pc_in[9:2]);
      end
      if (!found && instr_valid && dec_ready) begin
        found = 1'b1;
        checks++;
        if (instr_pc !== 10'd180 || instr !== 32'hA0 + 32'd45) begin
          errors++;
          $display("FAIL redir_first pc/instr act %0d/%h exp 180/%h", instr_pc, instr, 32'hA0 + 32'd45);
        end
      end
      advance();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL redir_timeout no delivery after redirect, exp pc 180");
    end
  endtask

  task automatic test_back_to_back();
    bit found = 1'b0;
    dec_ready = 1'b1;
    redirect  = 1'b1;
    target    = 10'd180;
    @(negedge clk); model_eval();
    advance();
    redirect = 1'b1;
    target   = 10'd250;
    @(negedge clk); model_eval();
    checks++;
    if (dut.state !== S_FLUSH || imem_en !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first state/en/valid act %0d/%b/%b exp %0d/0/0", dut.state, imem_en, instr_valid, S_FLUSH);
    end
    advance();
    @(negedge clk); model_eval();
    checks++;
    if (dut.state !== S_FLUSH || imem_en !== 1'b1 || imem_addr !== 8'(250 >> 2)) begin
      errors++;
      $display("FAIL b2b_second state/en/addr act %0d/%b/%0d exp %0d/1/%0d",
               dut.state, imem_en, imem_addr, S_FLUSH, 250 >> 2);
    end
    advance();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); model_eval();
      if (exp_valid) begin
        checks++;
        if ({instr, instr_pc, instr_misalign} !== {exp_instr, exp_pc, exp_mis}) begin
          errors++;
          $display("FAIL b2b_head c=%0d instr/pc/mis act %h/%0d/%b exp %h/%0d/%b",
                   c, instr, instr_pc, instr_misalign, exp_instr, exp_pc, exp_mis);
        end
      end
      if (!found && instr_valid && dec_ready) begin
        found = 1'b1;
        checks++;
        if (instr_pc !== 10'd250) begin
          errors++;
          $display("FAIL b2b_first_delivery pc act %0d exp 250", instr_pc);
        end
      end
      advance();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL b2b_timeout no delivery after redirects, exp pc 250");
    end
  endtask

  task automatic test_misalign();
    bit found = 1'b0;
    dec_ready = 1'b1;
    redirect  = 1'b1;
    target    = 10'd102;
    @(negedge clk); model_eval();
    advance();
    @(negedge clk); model_eval();
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 8'd25) begin
      errors++;
      $display("FAIL mis_addr en/addr act %b/%0d exp 1/25", imem_en, imem_addr);
    end
    advance();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); model_eval();
      if (!found && instr_valid && dec_ready) begin
        found = 1'b1;
        checks++;
        if ({instr, instr_pc, instr_misalign} !== {32'hA0 + 32'd25, 10'd102, 1'b1}) begin
          errors++;
          $display("FAIL mis_head instr/pc/mis act %h/%0d/%b exp %h/102/1",
                   instr, instr_pc, instr_misalign, 32'hA0 + 32'd25);
        end
      end
      advance();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL mis_timeout no delivery, exp pc 102");
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    dec_ready = 1'b0;
    for (int c = 0; c < 10 && q.size() < 2; c++) begin
      @(negedge clk); model_eval();
      checks++;
      if ({pc_stall, imem_en, instr_valid, imem_addr} !== {~exp_issue, exp_issue, exp_valid, pc_in[9:2]}) begin
        errors++;
        $display("FAIL ar_fill c=%0d stall/en/valid/addr act %b/%b/%b/%0d exp %b/%b/%b/%0d",
                 c, pc_stall, imem_en, instr_valid, imem_addr, ~exp_issue, exp_issue, exp_valid, pc_in[9:2]);
      end
      advance();
    end
    checks++;
    if (instr_valid !== 1'b1 || q.size() != 2) begin
      errors++;
      $display("FAIL ar_prefill valid act %b exp 1 (model occupancy %0d exp 2)", instr_valid, q.size());
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({instr_valid, imem_en, pc_stall} !== 3'b001) begin
      errors++;
      $display("FAIL ar_immediate valid/en/stall act %b/%b/%b exp 0/0/1", instr_valid, imem_en, pc_stall);
    end
    model_reset();
    pc        = 10'd100;
    pc_in     = 10'd100;
    dec_ready = 1'b1;
    redirect  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); model_eval();
      checks++;
      if ({pc_stall, imem_en, instr_valid, imem_addr} !== {~exp_issue, exp_issue, exp_valid, pc_in[9:2]}) begin
        errors++;
        $display("FAIL ar_restart c=%0d stall/en/valid/addr act %b/%b/%b/%0d exp %b/%b/%b/%0d",
                 c, pc_stall, imem_en, instr_valid, imem_addr, ~exp_issue, exp_issue, exp_valid, pc_in[9:2]);
      end
      if (!found && instr_valid && dec_ready) begin
        found = 1'b1;
        checks++;
        if (instr_pc !== 10'd100 || c != 3) begin
          errors++;
          $display("FAIL ar_first pc/cycle act %0d/%0d exp 100/3", instr_pc, c);
        end
      end
      advance();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout no delivery after reset release, exp pc 100");
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      dec_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 8) begin
        redirect = 1'b1;
        target   = 10'($urandom_range(0, 1023));
      end
      @(negedge clk); model_eval();
      checks++;
      if ({pc_stall, imem_en, instr_valid, imem_addr} !== {~exp_issue, exp_issue, exp_valid, pc_in[9:2]}) begin
        errors++;
        $display("FAIL rand_handshake c=%0d stall/en/valid/addr act %b/%b/%b/%0d exp %b/%b/%b/%0d",
                 c, pc_stall, imem_en, instr_valid, imem_addr, ~exp_issue, exp_issue, exp_valid, pc_in[9:2]);
      end
      if (exp_valid) begin
        checks++;
        if ({instr, instr_pc, instr_misalign} !== {exp_instr, exp_pc, exp_mis}) begin
          errors++;
          $display("FAIL rand_head c=%0d instr/pc/mis act %h/%0d/%b exp %h/%0d/%b",
                   c, instr, instr_pc, instr_misalign, exp_instr, exp_pc, exp_mis);
        end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_misalign();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
